// File: rtl/ttt_pkg.sv
// ttt_pkg: shared cell codes, FSM encoding and win-line table
// for the tic-tac-toe referee.
package ttt_pkg;

  localparam logic [1:0] C_EMPTY = 2'b00;
  localparam logic [1:0] C_X     = 2'b01;
  localparam logic [1:0] C_O     = 2'b10;

  localparam int NCELLS = 9;
  localparam int NLINES = 8;

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_CHECK = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // rows, columns, then the two diagonals
  localparam logic [3:0] WIN_LINES [NLINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // Out-of-range indices read as empty; callers range-check separately.
  function automatic logic [1:0] cell_at(
    input logic [17:0] b,
    input logic [3:0]  idx
  );
    logic [1:0] c;
    c = C_EMPTY;
    for (int k = 0; k < NCELLS; k++) begin
      if (idx == 4'(k)) c = b[2*k +: 2];
    end
    return c;
  endfunction

endpackage

// File: rtl/line_check_3.sv
// line_check_3: flags a line of three equal, occupied cells
// and reports which mark owns it.
module line_check_3
  import ttt_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] c,
  output logic       match,
  output logic [1:0] code
);

  assign match = (a != C_EMPTY) && (a == b) && (b == c);
  assign code  = match ? a : C_EMPTY;

endmodule

// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: two-player tic-tac-toe referee. Validates
// moves, holds the board and reports win or draw.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter logic FIRST_PLAYER = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        new_game,
  input  logic        req_x,
  input  logic [3:0]  pos_x,
  input  logic        req_o,
  input  logic [3:0]  pos_o,
  output logic        ack_x,
  output logic        ack_o,
  output logic        err,
  output logic [17:0] board,
  output logic        turn,
  output logic        game_over,
  output logic        winner,
  output logic [1:0]  who,
  output logic        draw
);

  state_t      state;
  logic [3:0]  moves;

  logic        cur_req;
  logic        oth_req;
  logic [3:0]  cur_pos;
  logic [1:0]  cur_code;
  logic        cur_ok;
  logic [17:0] board_wr;

  logic [NLINES-1:0] line_hit;
  logic [1:0]        line_code [NLINES];
  logic              any_win;
  logic [1:0]        win_code;

  assign cur_req  = turn ? req_o : req_x;
  assign oth_req  = turn ? req_x : req_o;
  assign cur_pos  = turn ? pos_o : pos_x;
  assign cur_code = turn ? C_O : C_X;
  assign cur_ok   = cur_req
                 && (cur_pos <= 4'd8)
                 && (cell_at(board, cur_pos) == C_EMPTY);

  // Board image with the mover's mark placed at cur_pos.
  always_comb begin
    board_wr = board;
    for (int k = 0; k < NCELLS; k++) begin
      if (cur_pos == 4'(k)) board_wr[2*k +: 2] = cur_code;
    end
  end

  for (genvar g = 0; g < NLINES; g++) begin : g_line
    logic [1:0] ca;
    logic [1:0] cb;
    logic [1:0] cc;
    assign ca = cell_at(board, WIN_LINES[g][0]);
    assign cb = cell_at(board, WIN_LINES[g][1]);
    assign cc = cell_at(board, WIN_LINES[g][2]);
    line_check_3 u_line (
      .a     (ca),
      .b     (cb),
      .c     (cc),
      .match (line_hit[g]),
      .code  (line_code[g])
    );
  end

  // Pick the owner of the lowest-numbered completed line.
  always_comb begin
    any_win  = |line_hit;
    win_code = C_EMPTY;
    for (int i = NLINES - 1; i >= 0; i--) begin
      if (line_hit[i]) win_code = line_code[i];
    end
  end

  // Game FSM; every output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PLAY;
      board     <= '0;
      moves     <= '0;
      turn      <= FIRST_PLAYER;
      ack_x     <= 1'b0;
      ack_o     <= 1'b0;
      err       <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
      who       <= C_EMPTY;
      draw      <= 1'b0;
    end else begin
      ack_x <= 1'b0;
      ack_o <= 1'b0;
      err   <= 1'b0;
      if (new_game) begin
        state     <= S_PLAY;
        board     <= '0;
        moves     <= '0;
        turn      <= FIRST_PLAYER;
        game_over <= 1'b0;
        winner    <= 1'b0;
        who       <= C_EMPTY;
        draw      <= 1'b0;
      end else begin
        unique case (state)
          S_PLAY: begin
            if (cur_ok) begin
              board <= board_wr;
              moves <= moves + 4'd1;
              state <= S_CHECK;
              ack_x <= ~turn;
              ack_o <= turn;
            end
            if ((cur_req && !cur_ok) || oth_req) begin
              err <= 1'b1;
            end
          end
          S_CHECK: begin
            if (any_win) begin
              winner    <= 1'b1;
              who       <= win_code;
              game_over <= 1'b1;
              state     <= S_DONE;
            end else if (moves == 4'd9) begin
              draw      <= 1'b1;
              game_over <= 1'b1;
              state     <= S_DONE;
            end else begin
              turn  <= ~turn;
              state <= S_PLAY;
            end
          end
          S_DONE: begin
            if (req_x || req_o) err <= 1'b1;
          end
          default: state <= S_PLAY;
        endcase
      end
    end
  end

endmodule
